prog_loader: RTL

- Streams a program image into the CPU's instruction RAM from a byte-wide valid/ready source, then releases the CPU from reset.
- Acts as the writer/front end of the program-image path. The simulation log/dump logic reads machine state out; this block writes the instruction image in.
- Sits between an external byte source (UART/testbench stream) and the instruction RAM write port, and owns the CPU reset line.

---
 rtl/loader_pkg.sv | 21 ++
 rtl/prog_loader_byte_packer.sv | 56 +++++
 rtl/prog_loader.sv | 128 ++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the program-image loader: state encoding and the
// default end-of-program marker.
package loader_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_WRITE = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_ERR   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_LOAD  = ST_LOAD,
        S_WRITE = ST_WRITE,
        S_DONE  = ST_DONE,
        S_ERR   = ST_ERR
    } state_e;

    localparam logic [31:0] END_WORD_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Big-endian byte-to-word assembler: the first byte of a group lands in
// [31:24], the fourth in [7:0]. Flags the fourth transfer of each group.
module byte_packer (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clr_i,
    input  logic        byte_en_i,
    input  logic [7:0]  byte_data_i,
    output logic        word_ready_o,
    output logic [31:0] word_o
);
    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] shift_q, shift_d;
    logic [31:0] word_q, word_d;
    logic        last_s;

    // Next-state for the byte counter, the partial-word shifter and the latched word.
    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        word_d  = word_q;
        last_s  = 1'b0;
        if (clr_i) begin
            cnt_d   = 2'd0;
            shift_d = 24'd0;
        end else if (byte_en_i) begin
            cnt_d   = cnt_q + 2'd1;
            shift_d = {shift_q[15:0], byte_data_i};
            if (cnt_q == 2'd3) begin
                word_d = {shift_q, byte_data_i};
                last_s = 1'b1;
            end else begin
                last_s = 1'b0;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Packer state registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q   <= 2'd0;
            shift_q <= 24'd0;
            word_q  <= 32'd0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            word_q  <= word_d;
        end
    end

    assign word_ready_o = last_s;
    assign word_o       = word_q;

endmodule

// File: rtl/prog_loader.sv
// Program image loader: accepts a byte stream, writes big-endian words into
// instruction RAM and holds the CPU in reset until an end marker is written.
module prog_loader
    import loader_pkg::*;
#(
    parameter int          ADDR_W   = 9,
    parameter logic [31:0] END_WORD = END_WORD_DEFAULT
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              START,
    input  logic              BYTE_VALID,
    input  logic [7:0]        BYTE_DATA,
    output logic              BYTE_READY,
    output logic              IMEM_WE,
    output logic [ADDR_W-1:0] IMEM_ADDR,
    output logic [31:0]       IMEM_WDATA,
    output logic              CPU_RESET,
    output logic              DONE,
    output logic              ERR_OVF,
    output logic [ADDR_W:0]   WORD_COUNT
);
    state_e            state_q;
    logic              byte_ready_q;
    logic              imem_we_q;
    logic              cpu_reset_q;
    logic              done_q;
    logic              err_ovf_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   count_q;

    logic              idle_like_s;
    logic              start_load_s;
    logic              byte_en_s;
    logic              word_ready_s;
    logic [31:0]       word_s;

    // A START pulse only launches a load from a resting state; bytes only move while ready.
    always_comb begin
        idle_like_s = 1'b0;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: idle_like_s = 1'b1;
            default:               idle_like_s = 1'b0;
        endcase
        start_load_s = START & idle_like_s;
        byte_en_s    = BYTE_VALID & byte_ready_q;
    end

    byte_packer u_packer (
        .clk_i        (CLOCK),
        .rst_ni       (RESET),
        .clr_i        (start_load_s),
        .byte_en_i    (byte_en_s),
        .byte_data_i  (BYTE_DATA),
        .word_ready_o (word_ready_s),
        .word_o       (word_s)
    );

    // Loader FSM with address/word counters and registered control outputs.
    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            state_q      <= S_IDLE;
            byte_ready_q <= 1'b0;
            imem_we_q    <= 1'b0;
            cpu_reset_q  <= 1'b1;
            done_q       <= 1'b0;
            err_ovf_q    <= 1'b0;
            addr_q       <= {ADDR_W{1'b0}};
            count_q      <= {(ADDR_W+1){1'b0}};
        end else begin
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start_load_s) begin
                        state_q      <= S_LOAD;
                        byte_ready_q <= 1'b1;
                        cpu_reset_q  <= 1'b1;
                        done_q       <= 1'b0;
                        err_ovf_q    <= 1'b0;
                        addr_q       <= {ADDR_W{1'b0}};
                        count_q      <= {(ADDR_W+1){1'b0}};
                    end
                end
                S_LOAD: begin
                    if (word_ready_s) begin
                        state_q      <= S_WRITE;
                        byte_ready_q <= 1'b0;
                        imem_we_q    <= 1'b1;
                    end
                end
                S_WRITE: begin
                    imem_we_q <= 1'b0;
                    addr_q    <= addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    count_q   <= count_q + {{ADDR_W{1'b0}}, 1'b1};
                    if (word_s == END_WORD) begin
                        // The marker itself is written so the CPU fetches a halt word.
                        state_q     <= S_DONE;
                        done_q      <= 1'b1;
                        cpu_reset_q <= 1'b0;
                    end else if (addr_q == {ADDR_W{1'b1}}) begin
                        state_q   <= S_ERR;
                        err_ovf_q <= 1'b1;
                    end else begin
                        state_q      <= S_LOAD;
                        byte_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    byte_ready_q <= 1'b0;
                    imem_we_q    <= 1'b0;
                    cpu_reset_q  <= 1'b1;
                    done_q       <= 1'b0;
                    err_ovf_q    <= 1'b0;
                end
            endcase
        end
    end

    assign BYTE_READY = byte_ready_q;
    assign IMEM_WE    = imem_we_q;
    assign IMEM_ADDR  = addr_q;
    assign IMEM_WDATA = word_s;
    assign CPU_RESET  = cpu_reset_q;
    assign DONE       = done_q;
    assign ERR_OVF    = err_ovf_q;
    assign WORD_COUNT = count_q;

endmodule
